// File: rtl/periph_bus_arbiter.sv
// Two-port round-robin arbiter onto the peripheral register bus.
// Ports: clk/rst, m0_*/m1_* requesters, p_* peripheral bus, busy, gnt_id.
module periph_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] p_addr,
  output logic          p_wr,
  output logic          p_re,
  output logic [DW-1:0] p_wdata,
  input  logic [DW-1:0] p_rdata,
  output logic          busy,
  output logic          gnt_id
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Contention goes to the port not served last.
          win     = (m0_req && m1_req) ? ~last_q : m1_req;
          gnt_d   = win;
          wr_d    = win ? m1_wr : m0_wr;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          cnt_d   = CW'(ACCESS_CYCLES - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = wr_q ? '0 : p_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_addr   = '0;
    p_wdata  = '0;
    p_wr     = 1'b0;
    p_re     = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (state_q == ACCESS) begin
      p_addr  = addr_q;
      p_wdata = wdata_q;
      p_re    = ~wr_q;
      // Single write strobe so side-effect registers fire once.
      p_wr    = wr_q && (cnt_q == '0);
    end
    if (state_q == RESP) begin
      m0_ack   = ~gnt_q;
      m1_ack   = gnt_q;
      m0_rdata = gnt_q ? '0 : rdata_q;
      m1_rdata = gnt_q ? rdata_q : '0;
    end
  end

  assign busy   = (state_q != IDLE);
  assign gnt_id = gnt_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: directed cases,
// randomized two-master traffic, and an ACCESS_CYCLES=1 build.
module tb_periph_bus_arbiter;

  localparam int AC = 2;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, p_wr, p_re, busy, gnt_id;
  logic [31:0] m0_rdata, m1_rdata, p_addr, p_wdata, p_rdata;

  logic        s_req = 0;
  logic [31:0] s_addr = 0;
  logic        s_m0_ack, s_m1_ack, s_p_wr, s_p_re, s_busy, s_gnt;
  logic [31:0] s_m0_rdata, s_m1_rdata, s_p_addr, s_p_wdata, s_p_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  txn_t q0[$];
  txn_t q1[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] periph_f(logic [31:0] a);
    if (a == 32'h0080_0000) return 32'h0000_1234;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign p_rdata   = periph_f(p_addr);
  assign s_p_rdata = periph_f(s_p_addr);

  periph_bus_arbiter #(.ACCESS_CYCLES(AC), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .p_addr(p_addr), .p_wr(p_wr), .p_re(p_re),
    .p_wdata(p_wdata), .p_rdata(p_rdata),
    .busy(busy), .gnt_id(gnt_id)
  );

  periph_bus_arbiter #(.ACCESS_CYCLES(1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .rst(rst),
    .m0_req(s_req), .m0_wr(1'b0), .m0_addr(s_addr),
    .m0_wdata(32'h0), .m0_ack(s_m0_ack), .m0_rdata(s_m0_rdata),
    .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(32'h0),
    .m1_wdata(32'h0), .m1_ack(s_m1_ack), .m1_rdata(s_m1_rdata),
    .p_addr(s_p_addr), .p_wr(s_p_wr), .p_re(s_p_re),
    .p_wdata(s_p_wdata), .p_rdata(s_p_rdata),
    .busy(s_busy), .gnt_id(s_gnt)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bus owner, beat index within the transaction,
  // and the round-robin memory, advanced once per cycle.
  bit   act = 0;
  int   k = 0;
  bit   cur = 0;
  bit   last = 1;
  bit   gnt_m = 0;
  txn_t t;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", busy, act);
      chk("gnt_id", gnt_id, gnt_m);
      if (act && k <= AC) begin
        chk("p_addr", p_addr, t.addr);
        chk("p_wdata", p_wdata, t.wdata);
        chk("p_re", p_re, !t.wr);
        chk("p_wr", p_wr, t.wr && k == AC);
        chk("ack_acc", {m1_ack, m0_ack}, 0);
        chk("rdata_acc", m0_rdata | m1_rdata, 0);
      end else begin
        chk("p_addr_idle", p_addr, 0);
        chk("p_wdata_idle", p_wdata, 0);
        chk("strobe_idle", {p_wr, p_re}, 0);
        if (act) begin
          chk("ack_resp", {m1_ack, m0_ack}, cur ? 2'b10 : 2'b01);
          chk("rdata_own", cur ? m1_rdata : m0_rdata, t.rdata);
          chk("rdata_other", cur ? m0_rdata : m1_rdata, 0);
        end else begin
          chk("ack_idle", {m1_ack, m0_ack}, 0);
          chk("rdata_idle", m0_rdata | m1_rdata, 0);
        end
      end
      if (rst) begin
        act = 0; last = 1; gnt_m = 0;
      end else if (act) begin
        if (k == AC + 1) begin
          act = 0;
          last = cur;
          if (cur) void'(q1.pop_front());
          else void'(q0.pop_front());
        end else begin
          k++;
        end
      end else if (m0_req || m1_req) begin
        cur = (m0_req && m1_req) ? !last : m1_req;
        gnt_m = cur;
        act = 1;
        k = 1;
        if (cur ? q1.size() == 0 : q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_no_txn: port %0d", cur);
        end else begin
          t = cur ? q1[0] : q0[0];
        end
      end
    end
  end

  task automatic raise(bit p, bit wr, logic [31:0] a, logic [31:0] d);
    txn_t x;
    x.wr = wr; x.addr = a; x.wdata = d;
    x.rdata = wr ? 32'h0 : periph_f(a);
    if (p) begin
      m1_req = 1; m1_wr = wr; m1_addr = a; m1_wdata = d; q1.push_back(x);
    end else begin
      m0_req = 1; m0_wr = wr; m0_addr = a; m0_wdata = d; q0.push_back(x);
    end
  endtask

  task automatic wait_ack_drop(bit p);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = p ? m1_ack : m0_ack;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: port %0d got 0 want 1", p);
    end
    @(posedge clk); #1;
    if (p) m1_req = 0; else m0_req = 0;
  endtask

  task automatic txn(bit p, bit wr, logic [31:0] a, logic [31:0] d);
    raise(p, wr, a, d);
    wait_ack_drop(p);
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic master(bit p, int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 3));
      txn(p, 1'($urandom), $urandom, $urandom);
    end
  endtask

  initial begin
    idle(3);
    rst = 0;
    idle(1);
    txn(0, 1, 32'h0040_0000, 32'h0000_00A5);
    idle(2);
    txn(1, 0, 32'h0080_0000, 32'h0);
    idle(2);
    fork
      begin txn(0, 0, 32'h100, 0); txn(0, 1, 32'h104, 7); end
      begin txn(1, 1, 32'h200, 9); txn(1, 0, 32'h204, 0); end
    join
    idle(2);
    for (int i = 0; i < 3; i++) txn(0, 1, 32'h300 + i, 32'hC0 + i);
    idle(2);
    raise(0, 1, 32'h0040_0010, 32'h5A);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    wait_ack_drop(0);
    idle(2);
    s_req = 1; s_addr = 32'h0000_0ABC;
    @(negedge clk);
    chk("ac1_idle_re", s_p_re, 0);
    @(negedge clk);
    chk("ac1_re", s_p_re, 1);
    chk("ac1_addr", s_p_addr, 32'h0000_0ABC);
    chk("ac1_ack_early", s_m0_ack, 0);
    @(negedge clk);
    chk("ac1_re_end", s_p_re, 0);
    chk("ac1_ack", s_m0_ack, 1);
    chk("ac1_rdata", s_m0_rdata, periph_f(32'h0000_0ABC));
    @(posedge clk); #1;
    s_req = 0;
    @(negedge clk);
    chk("ac1_ack_after", s_m0_ack, 0);
    chk("ac1_busy_after", s_busy, 0);
    idle(2);
    fork
      master(0, 25);
      master(1, 25);
    join
    idle(4);
    chk("q_empty", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

endmodule
